// File: rtl/caxi4interconnect_id_reg_arbiter.sv
// Round-robin arbiter sharing a small read-only ID/status register bank
// between NUM_REQ requesters, returning data after a fixed latency.
module caxi4interconnect_id_reg_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [31:0]          DEV_REVISION,
    input  logic [NUM_REQ-1:0]   REQ_VALID,
    input  logic [3*NUM_REQ-1:0] REQ_ADDR,
    output logic [NUM_REQ-1:0]   REQ_READY,
    output logic [NUM_REQ-1:0]   RSP_VALID,
    input  logic [NUM_REQ-1:0]   RSP_READY,
    output logic [31:0]          RSP_DATA,
    output logic                 RSP_ERR
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         gnt_q, gnt_d;
    logic [2:0]         addr_q, addr_d;
    logic [2:0]         last_grant_q, last_grant_d;
    logic [3:0]         lat_q, lat_d;
    logic [31:0]        served_q, served_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

    logic [7:0]         vld8;
    logic [7:0]         rsp_rdy8;
    logic [23:0]        addr24;
    logic [4:0]         addr_sel;
    logic               found;
    logic [2:0]         winner;
    logic [31:0]        rd_data;
    logic               rd_err;

    assign vld8     = 8'(REQ_VALID);
    assign rsp_rdy8 = 8'(RSP_READY);
    assign addr24   = 24'(REQ_ADDR);
    assign addr_sel = 5'(winner) * 5'd3;

    // First requesting index at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        logic [3:0] idx;
        found  = 1'b0;
        winner = 3'd0;
        idx    = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = 4'(ptr_q) + 4'(k);
            if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
            if (!found && vld8[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

    assign REQ_READY = (state_q == IDLE && found && !ARESET) ? NUM_REQ'(8'h01 << winner) : '0;

    always_comb begin
        rd_data = 32'h0;
        rd_err  = 1'b0;
        case (addr_q)
            3'd0:    rd_data = DEV_REVISION;
            3'd1:    rd_data = {16'h0, 8'(NUM_REQ), 4'h0, 4'(RD_LATENCY)};
            3'd2:    rd_data = served_q;
            3'd3:    rd_data = {err_cnt_q, 8'h00, 5'b0, last_grant_q};
            default: rd_err  = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        addr_d       = addr_q;
        last_grant_d = last_grant_q;
        lat_d        = lat_q;
        served_d     = served_q;
        err_cnt_d    = err_cnt_q;
        data_d       = data_q;
        err_d        = err_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d        = winner;
                    addr_d       = addr24[addr_sel +: 3];
                    last_grant_d = winner;
                    ptr_d        = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
                    lat_d        = 4'(RD_LATENCY - 1);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                // Counters are sampled here, so an addr-2 read sees the pre-transaction count.
                if (lat_q == 4'd0) begin
                    state_d     = RESP;
                    data_d      = rd_data;
                    err_d       = rd_err;
                    rsp_valid_d = NUM_REQ'(8'h01 << gnt_q);
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_rdy8[gnt_q]) begin
                    served_d = served_q + 32'd1;
                    if (err_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    state_d     = IDLE;
                    rsp_valid_d = '0;
                    data_d      = 32'h0;
                    err_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            ptr_q        <= 3'd0;
            last_grant_q <= 3'd0;
            lat_q        <= 4'd0;
            served_q     <= 32'h0;
            err_cnt_q    <= 16'h0;
            data_q       <= 32'h0;
            err_q        <= 1'b0;
            rsp_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            last_grant_q <= last_grant_d;
            lat_q        <= lat_d;
            served_q     <= served_d;
            err_cnt_q    <= err_cnt_d;
            data_q       <= data_d;
            err_q        <= err_d;
            rsp_valid_q  <= rsp_valid_d;
            gnt_q        <= gnt_d;
            addr_q       <= addr_d;
        end
    end

    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = data_q;
    assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_caxi4interconnect_id_reg_arbiter.sv
// Bench for the ID register arbiter: transaction-level model checked every cycle
// on a 4-requester/latency-2 instance, plus directed checks on a 3/1 instance.
module tb_caxi4interconnect_id_reg_arbiter;
    localparam int N = 4;
    localparam int LAT = 2;
    localparam logic [31:0] REV = 32'h15062901;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [3*N-1:0] req_addr = '0;
    logic [N-1:0]   rsp_ready = '1;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [31:0]    rsp_data;
    logic           rsp_err;

    logic [2:0]  b_req_valid = '0;
    logic [8:0]  b_req_addr = '0;
    logic [2:0]  b_rsp_ready = '1;
    logic [2:0]  b_req_ready, b_rsp_valid;
    logic [31:0] b_rsp_data;
    logic        b_rsp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    caxi4interconnect_id_reg_arbiter #(.NUM_REQ(N), .RD_LATENCY(LAT)) dut (
        .ACLK(clk), .ARESET(rst), .DEV_REVISION(REV),
        .REQ_VALID(req_valid), .REQ_ADDR(req_addr), .REQ_READY(req_ready),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err));

    caxi4interconnect_id_reg_arbiter #(.NUM_REQ(3), .RD_LATENCY(1)) dut_b (
        .ACLK(clk), .ARESET(rst), .DEV_REVISION(REV),
        .REQ_VALID(b_req_valid), .REQ_ADDR(b_req_addr), .REQ_READY(b_req_ready),
        .RSP_VALID(b_rsp_valid), .RSP_READY(b_rsp_ready), .RSP_DATA(b_rsp_data), .RSP_ERR(b_rsp_err));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (t=%0t)", name, $time);
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (|(v & onehot((p + k) % N))) return (p + k) % N;
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (|(v & onehot(i))) return i;
        return -1;
    endfunction

    // Transaction-level model: phase 0 idle, 1 waiting (age = edges since accept), 2 responding.
    int          m_phase = 0, m_age = 0, m_gnt = 0, m_ptr = 0, m_last = 0, m_err_cnt = 0;
    logic [2:0]  m_addr = '0;
    logic [31:0] m_served = '0, m_data = '0;
    logic        m_err = 1'b0;

    function automatic logic [32:0] model_rd(input logic [2:0] a);
        case (a)
            3'd0:    return {1'b0, REV};
            3'd1:    return {1'b0, 32'h0000_0402};
            3'd2:    return {1'b0, m_served};
            3'd3:    return {1'b0, 16'(m_err_cnt), 13'h0, 3'(m_last)};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_served = '0; m_err_cnt = 0; m_last = 0;
            m_data = '0; m_err = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    w = pick(req_valid, m_ptr);
                    if (w >= 0) begin
                        m_gnt = w; m_addr = 3'(req_addr >> (3 * w)); m_last = w;
                        m_ptr = (w + 1) % N; m_age = 0; m_phase = 1;
                    end
                end
                1: begin
                    m_age++;
                    if (m_age == LAT) begin
                        {m_err, m_data} = model_rd(m_addr);
                        m_phase = 2;
                    end
                end
                default: begin
                    if (|(rsp_ready & onehot(m_gnt))) begin
                        m_served = m_served + 32'd1;
                        if (m_err && m_err_cnt < 65535) m_err_cnt++;
                        m_phase = 0; m_data = '0; m_err = 1'b0;
                    end
                end
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            int w;
            logic [N-1:0] er, ev;
            w  = pick(req_valid, m_ptr);
            er = (!rst && m_phase == 0 && w >= 0) ? onehot(w) : '0;
            ev = (m_phase == 2) ? onehot(m_gnt) : '0;
            chk("model_req_ready", 32'(req_ready), 32'(er));
            chk("model_rsp_valid", 32'(rsp_valid), 32'(ev));
            chk("model_rsp_data", rsp_data, (m_phase == 2) ? m_data : 32'h0);
            chk("model_rsp_err", 32'(rsp_err), 32'(m_phase == 2 && m_err));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; b_req_valid = '0; rsp_ready = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_read(input int r, input logic [2:0] a,
                           output logic [31:0] d, output logic e, output int lat);
        int t;
        @(negedge clk);
        req_valid = req_valid | onehot(r);
        req_addr  = (req_addr & ~(12'h7 << (3 * r))) | (12'(a) << (3 * r));
        #1;
        t = 0;
        while (!(|(req_ready & onehot(r))) && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) fail("read_grant");
        @(posedge clk);
        @(negedge clk);
        req_valid = req_valid & ~onehot(r);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!(|(rsp_valid & onehot(r))) && lat < 50);
        if (lat >= 50) fail("read_rsp");
        d = rsp_data;
        e = rsp_err;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic e;
        int lat, t, g, gcyc, prev;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data", rsp_data, 32'h0);
        do_reset();

        // Single read of the revision word
        do_read(0, 3'd0, d, e, lat);
        chk("single_data", d, 32'h15062901);
        chk("single_err", 32'(e), 32'h0);
        chk("single_latency", lat, 2);
        chk("single_valid", 32'(rsp_valid), 32'h1);

        // Round robin with everyone requesting the served count
        do_reset();
        @(negedge clk);
        req_addr = {4{3'd2}};
        req_valid = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            t = 0;
            while (req_ready == '0 && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) fail("rr_grant_wait");
            g = idx_of(req_ready);
            gcyc = cyc;
            chk("rr_grant", g, i % 4);
            if (i > 0) chk("rr_period", gcyc - prev, 4);
            prev = gcyc;
            t = 0;
            while (rsp_valid == '0 && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) fail("rr_rsp_wait");
            chk("rr_count", rsp_data, i);
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(onehot(i % 4)));
        end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(posedge clk);

        // Bad addresses then the status word
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_read(2, 3'd5, d, e, lat);
            chk("bad_data", d, 32'h0);
            chk("bad_err", 32'(e), 32'h1);
        end
        do_read(2, 3'd3, d, e, lat);
        chk("status_word", d, 32'h0003_0002);
        chk("status_err", 32'(e), 32'h0);

        // Backpressure
        do_reset();
        @(negedge clk);
        rsp_ready = '0;
        do_read(0, 3'd0, d, e, lat);
        chk("bp_data", d, 32'h15062901);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 3) begin
                req_valid = 4'b0010;
                req_addr = (req_addr & ~12'h038) | (12'd1 << 3);
            end
            @(posedge clk); #1;
            chk("bp_valid_hold", 32'(rsp_valid), 32'h1);
            chk("bp_data_hold", rsp_data, 32'h15062901);
            chk("bp_no_grant", 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        rsp_ready = '1;
        @(posedge clk); #1;
        chk("bp_grant_after", 32'(req_ready), 32'h2);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(posedge clk);

        // Reset mid-transaction
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        req_addr = '0;
        #1;
        t = 0;
        while (req_ready == '0 && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) fail("midrst_grant");
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", 32'(rsp_valid), 32'h0);
        end
        do_read(3, 3'd2, d, e, lat);
        chk("midrst_count", d, 32'h0);
        @(negedge clk);
        req_valid = 4'b1111;
        req_addr = '0;
        #1;
        t = 0;
        while (req_ready == '0 && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) fail("midrst_all_grant");
        chk("midrst_winner", 32'(req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(posedge clk);

        // Three requesters, latency 1
        @(negedge clk);
        b_req_valid = 3'b100;
        b_req_addr = 9'd1 << 6;
        #1;
        t = 0;
        while (b_req_ready == '0 && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) fail("cfg_grant");
        chk("cfg_grant", 32'(b_req_ready), 32'h4);
        @(posedge clk);
        @(negedge clk);
        b_req_valid = '0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (b_rsp_valid == '0 && lat < 50);
        chk("cfg_latency", lat, 1);
        chk("cfg_data", b_rsp_data, 32'h0000_0301);
        chk("cfg_valid", 32'(b_rsp_valid), 32'h4);
        chk("cfg_err", 32'(b_rsp_err), 32'h0);
        @(negedge clk);
        b_req_valid = 3'b111;
        b_req_addr = '0;
        #1;
        t = 0;
        while (b_req_ready == '0 && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) fail("cfg_wrap_grant");
        chk("cfg_wrap_winner", 32'(b_req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        b_req_valid = '0;
        repeat (4) @(posedge clk);

        chk_en = 1'b0;
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
